// File: rtl/cache_pkg.sv
// Shared cache geometry types and helpers for the miss handler and tag arrays.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int BLK_WORDS = 8;
    localparam int ADDR_BITS = 16;
    localparam int OFF_W     = $clog2(BLK_WORDS);
    localparam int INDEX_W   = 4;
    localparam int TAG_W     = ADDR_BITS - INDEX_W - OFF_W - 1;

    // Byte address of the first byte of the block holding addr (16-bit words).
    function automatic logic [31:0] block_base(input logic [31:0] addr, input int off_w);
        return addr & ~((32'd1 << (off_w + 1)) - 32'd1);
    endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Mod-MOD word counter: sync clear, enable, and a done flag that saturates after one full lap.
module fill_word_counter #(
    parameter int MOD = 8,
    localparam int W = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            done  <= 1'b0;
        end else if (en && !done) begin
            if (count == W'(MOD - 1)) begin
                count <= '0;
                done  <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: streams one block from memory into the data array, then writes the tag.
// CRITICAL_WORD_FIRST_EN: start the block at the missing word and pulse critical_word_ready.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int ADDR_W          = 16,
    localparam int OFF_W          = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              memory_request,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              write_data_array,
    output logic [OFF_W-1:0]  fill_word,
    output logic [15:0]       fill_data,
    output logic              write_tag_array,
    output logic              critical_word_ready
);
    import cache_pkg::*;

    if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 ||
        MEM_LATENCY < 1 || ADDR_W <= OFF_W + 1 || ADDR_W > 32) begin : g_bad_cfg
        $error("cache_fill_fsm: unsupported parameter combination");
    end

    fill_state_t       state;
    logic [ADDR_W-1:0] blk_base;
    logic [OFF_W-1:0]  start_off, miss_off, req_cnt, rsp_cnt, word_k;
    logic              req_done, rsp_done, hold_off, accept, in_fill, rsp_last;

`ifdef CRITICAL_WORD_FIRST_EN
    assign miss_off            = miss_address[OFF_W:1];
    assign critical_word_ready = write_data_array && (rsp_cnt == '0);
`else
    assign miss_off            = '0;
    assign critical_word_ready = 1'b0;
`endif

    // hold_off masks the cycle right after a fill so the stalled access re-reads its tag first.
    assign in_fill          = (state == FILL);
    assign accept           = (state == IDLE) && miss_detected && !hold_off;
    assign fsm_busy         = in_fill || accept;

    assign memory_request   = in_fill && !req_done;
    assign word_k           = req_cnt + start_off;
    assign memory_address   = memory_request ? (blk_base | ADDR_W'({word_k, 1'b0})) : '0;

    assign write_data_array = in_fill && memory_data_valid && !rsp_done;
    assign fill_word        = in_fill ? OFF_W'(rsp_cnt + start_off) : '0;
    assign fill_data        = memory_data;
    assign rsp_last         = (rsp_cnt == OFF_W'(WORDS_PER_BLOCK - 1));
    assign write_tag_array  = write_data_array && rsp_last;

    fill_word_counter #(.MOD(WORDS_PER_BLOCK)) u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (memory_request),
        .count (req_cnt),
        .done  (req_done)
    );

    fill_word_counter #(.MOD(WORDS_PER_BLOCK)) u_rsp_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (write_data_array),
        .count (rsp_cnt),
        .done  (rsp_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            blk_base  <= '0;
            start_off <= '0;
            hold_off  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold_off <= 1'b0;
                    if (accept) begin
                        blk_base  <= ADDR_W'(block_base(32'(miss_address), OFF_W));
                        start_off <= miss_off;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (write_tag_array) begin
                        state    <= IDLE;
                        hold_off <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: timeline model of each fill plus an in-order latency memory model.
module tb_cache_fill_fsm;
    localparam int N   = 8;
    localparam int AW  = 16;
    localparam int OW  = 3;
    localparam int LAT = 4;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, miss_detected, memory_data_valid;
    logic [AW-1:0] miss_address, memory_address;
    logic [15:0]   memory_data, fill_data;
    logic          fsm_busy, memory_request, write_data_array, write_tag_array, critical_word_ready;
    logic [OW-1:0] fill_word;

    always #5 clk = ~clk;

    cache_fill_fsm #(.WORDS_PER_BLOCK(N), .MEM_LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .miss_detected       (miss_detected),
        .miss_address        (miss_address),
        .fsm_busy            (fsm_busy),
        .memory_request      (memory_request),
        .memory_address      (memory_address),
        .memory_data_valid   (memory_data_valid),
        .memory_data         (memory_data),
        .write_data_array    (write_data_array),
        .fill_word           (fill_word),
        .fill_data           (fill_data),
        .write_tag_array     (write_tag_array),
        .critical_word_ready (critical_word_ready)
    );

    typedef struct {
        int          due;
        logic [15:0] addr;
    } pend_t;

    pend_t         pend[$];
    int            cyc, checks, failures, mem_lat;
    logic [15:0]   salt;
    bit            spurious;
    logic          s_busy, s_req, s_wr, s_tag, s_cwr;
    logic [AW-1:0] s_addr;
    logic [OW-1:0] s_fw;
    logic [15:0]   s_fd;
    logic [15:0]   arr [N];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    // One clock: drive memory response, sample outputs mid-cycle, log requests and writes.
    task automatic cycle();
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else if (spurious) begin
            memory_data_valid = 1'b1;
        end
        #4;
        s_busy = fsm_busy;       s_req = memory_request;   s_addr = memory_address;
        s_wr   = write_data_array; s_fw = fill_word;       s_fd   = fill_data;
        s_tag  = write_tag_array;  s_cwr = critical_word_ready;
        if (s_req) pend.push_back(pend_t'{cyc + mem_lat, s_addr});
        if (s_wr) arr[s_fw] = s_fd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Miss at local cycle 0: requests in 1..N, data in lat+1..N+lat, busy drops at N+lat+1.
    task automatic run_fill(input logic [15:0] addr, input int lat, input int rst_at,
                            input bit stray, input bit hold, input logic [15:0] next_addr);
        logic [15:0] base;
        int          off, k;
        bit          gone;
        base    = addr & 16'hFFF0;
        off     = CWF ? int'(addr[3:1]) : 0;
        mem_lat = lat;
        for (int w = 0; w < N; w++) arr[w] = 'x;
        miss_detected = 1'b1;
        miss_address  = addr;
        cycle();
        chk("busy_on_miss", s_busy, 1);
        chk("no_req_on_miss", s_req, 0);
        miss_detected = 1'b0;
        for (int i = 1; i <= N + lat + 1; i++) begin
            gone = (rst_at > 0) && (i > rst_at);
            if (stray && i == 3) begin
                miss_detected = 1'b1;
                miss_address  = addr ^ 16'h0F00;
            end
            if (hold && i == N + lat) begin
                miss_detected = 1'b1;
                miss_address  = next_addr;
            end
            rst = (i == rst_at);
            cycle();
            rst = 1'b0;
            if (stray && i == 3) miss_detected = 1'b0;
            chk("busy", s_busy, !gone && i <= N + lat);
            chk("req", s_req, !gone && i <= N);
            if (!gone && i <= N)
                chk("req_addr", s_addr, base + 16'(2 * ((i - 1 + off) % N)));
            chk("wr", s_wr, !gone && i > lat && i <= N + lat);
            if (!gone && i > lat && i <= N + lat) begin
                k = (i - 1 - lat + off) % N;
                chk("fill_word", s_fw, k);
                chk("fill_data", s_fd, mem_word(base + 16'(2 * k)));
            end
            chk("tag", s_tag, !gone && i == N + lat);
            chk("cwr", s_cwr, CWF && !gone && i == lat + 1);
        end
        if (rst_at == 0)
            for (int w = 0; w < N; w++) chk("block_word", arr[w], mem_word(base + 16'(2 * w)));
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; spurious = 1'b0; mem_lat = LAT;
        salt = 16'($urandom);
        rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
        memory_data_valid = 1'b0; memory_data = '0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        cycle();
        chk("rst_busy", s_busy, 0);
        chk("rst_req", s_req, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_wr", s_wr, 0);
        chk("rst_fill_word", s_fw, 0);
        chk("rst_tag", s_tag, 0);
        chk("rst_cwr", s_cwr, 0);

        run_fill(16'h1234, LAT, 0, 1'b0, 1'b0, 16'h0);
        run_fill(16'h123A, LAT, 0, 1'b0, 1'b0, 16'h0);

        spurious = 1'b1;
        repeat (3) begin
            cycle();
            chk("idle_valid_wr", s_wr, 0);
            chk("idle_valid_tag", s_tag, 0);
            chk("idle_valid_busy", s_busy, 0);
        end
        spurious = 1'b0;

        run_fill(16'h5678, LAT, 0, 1'b1, 1'b0, 16'h0);

        run_fill(16'h1234, LAT, LAT + 3, 1'b0, 1'b0, 16'h0);
        run_fill(16'h0040, LAT, 0, 1'b0, 1'b0, 16'h0);

        run_fill(16'h0010, LAT, 0, 1'b0, 1'b1, 16'h0020);
        run_fill(16'h0020, LAT, 0, 1'b0, 1'b0, 16'h0);

        rst = 1'b1; miss_detected = 1'b1; miss_address = 16'h3000;
        cycle();
        rst = 1'b0; miss_detected = 1'b0;
        cycle();
        chk("rst_prio_req", s_req, 0);
        chk("rst_prio_busy", s_busy, 0);

        repeat (6) begin
            run_fill(16'($urandom), int'($urandom_range(1, 6)), 0, 1'($urandom_range(0, 1)), 1'b0, 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
